strike_resolver: RTL and testbench



---
 rtl/battleship_pkg.sv | 51 +++++
 rtl/ship_map_lookup.sv | 31 +++
 rtl/strike_resolver.sv | 204 ++++++++++++++++++++
 tb/tb_strike_resolver.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/battleship_pkg.sv
// Shared Battleship types: ship codes, the fixed fleet layout and the resolver FSM states.
package battleship_pkg;

    localparam int unsigned SHIP_CODE_W   = 5;
    localparam int unsigned BOARD_COORD_W = 4;
    localparam int unsigned NUM_SHIPS     = 4;

    typedef logic [SHIP_CODE_W-1:0] ship_code_t;

    localparam ship_code_t WATER      = 5'd0;
    localparam ship_code_t DESTROYER  = 5'd2;
    localparam ship_code_t SUBMARINE  = 5'd3;
    localparam ship_code_t BATTLESHIP = 5'd4;
    localparam ship_code_t CARRIER    = 5'd5;

    typedef struct packed {
        ship_code_t               code;
        logic [BOARD_COORD_W-1:0] x0;
        logic [BOARD_COORD_W-1:0] y0;
        logic [2:0]               len;
        logic                     vert;
    } ship_place_t;

    // Each ship is an anchor cell plus a length running right (vert=0) or down (vert=1).
    localparam ship_place_t [NUM_SHIPS-1:0] FLEET = {
        ship_place_t'{CARRIER,    4'd1, 4'd2, 3'd5, 1'b0},
        ship_place_t'{BATTLESHIP, 4'd0, 4'd5, 3'd4, 1'b1},
        ship_place_t'{SUBMARINE,  4'd4, 4'd6, 3'd3, 1'b0},
        ship_place_t'{DESTROYER,  4'd8, 4'd8, 3'd2, 1'b1}
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FINISH = 2'd2
    } state_t;

    function automatic logic ship_covers(input ship_place_t p, input int cx, input int cy);
        int x0;
        int y0;
        int len;
        x0  = int'(p.x0);
        y0  = int'(p.y0);
        len = int'(p.len);
        if (p.vert) begin
            return (cx == x0) && (cy >= y0) && (cy < y0 + len);
        end
        return (cy == y0) && (cx >= x0) && (cx < x0 + len);
    endfunction

endpackage

// File: rtl/ship_map_lookup.sv
// Combinational board lookup: signed cell coordinate to ship code, WATER off the board.
module ship_map_lookup
    import battleship_pkg::*;
#(
    parameter int unsigned GRID_W  = 10,
    parameter int unsigned GRID_H  = 10,
    parameter int unsigned COORD_W = 4
) (
    input  logic signed [COORD_W:0] cx,
    input  logic signed [COORD_W:0] cy,
    output ship_code_t              ship_c
);

    int cx_i;
    int cy_i;

    assign cx_i = int'(cx);
    assign cy_i = int'(cy);

    always_comb begin
        ship_c = WATER;
        if (cx_i >= 0 && cx_i < int'(GRID_W) && cy_i >= 0 && cy_i < int'(GRID_H)) begin
            for (int i = 0; i < int'(NUM_SHIPS); i++) begin
                if (ship_covers(FLEET[i], cx_i, cy_i)) begin
                    ship_c = FLEET[i].code;
                end
            end
        end
    end

endmodule

// File: rtl/strike_resolver.sv
// Sequential bomb resolver: scans the (2r+1)^2 strike area one cell per clock and
// accumulates hit statistics, a per-cell hit mask and a saturating running total.
module strike_resolver #(
    parameter int unsigned GRID_W     = 10,
    parameter int unsigned GRID_H     = 10,
    parameter int unsigned COORD_W    = 4,
    parameter int unsigned MAX_RADIUS = 2,
    parameter int unsigned RAD_W      = 2,
    parameter int unsigned SHIP_W     = 5,
    parameter int unsigned CNT_W      = 5,
    parameter int unsigned TOTAL_W    = 7
) (
    input  logic               clock,
    input  logic               reset_L,
    input  logic               start,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [RAD_W-1:0]   radius,
    input  logic               wrong,
    input  logic               score_this,
    input  logic               clear_board,
    output logic               busy,
    output logic               done,
    output logic               temp_hit,
    output logic [CNT_W-1:0]   num_hits,
    output logic [CNT_W-1:0]   new_hits,
    output logic [SHIP_W-1:0]  biggest_ship,
    output logic [TOTAL_W-1:0] total_hits
);
    import battleship_pkg::*;

    localparam int unsigned CELLS = GRID_W * GRID_H;
    localparam int unsigned IDX_W = $clog2(CELLS);
    localparam int unsigned OFF_W = COORD_W + 1;

    typedef logic signed [OFF_W-1:0] off_t;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [RAD_W-1:0]   r_q, r_d;
    off_t               dx_q, dx_d, dy_q, dy_d;
    logic               busy_q, busy_d, done_q, done_d, temp_hit_q, temp_hit_d;
    logic [CNT_W-1:0]   num_q, num_d, new_q, new_d;
    logic [SHIP_W-1:0]  big_q, big_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic [CELLS-1:0]   mask_q, mask_d;

    off_t               r_s_c, cell_x_c, cell_y_c;
    logic               last_cell_c, start_ok_c;
    logic [RAD_W-1:0]   r_clamp_c;
    logic [IDX_W-1:0]   idx_c;
    logic [SHIP_W-1:0]  ship_w_c;
    logic [TOTAL_W:0]   sum_c;
    ship_code_t         ship_c;

    assign r_s_c       = $signed(OFF_W'(r_q));
    assign cell_x_c    = $signed(OFF_W'(x_q)) + dx_q;
    assign cell_y_c    = $signed(OFF_W'(y_q)) + dy_q;
    assign last_cell_c = (dx_q == r_s_c) && (dy_q == r_s_c);
    assign start_ok_c  = start && !wrong && score_this;
    assign r_clamp_c   = (32'(radius) > MAX_RADIUS) ? RAD_W'(MAX_RADIUS) : radius;
    assign idx_c       = IDX_W'(int'(cell_y_c) * int'(GRID_W) + int'(cell_x_c));
    assign ship_w_c    = SHIP_W'(ship_c);

    // One shared lookup, addressed by the current scan cell.
    ship_map_lookup #(
        .GRID_W  (GRID_W),
        .GRID_H  (GRID_H),
        .COORD_W (COORD_W)
    ) u_lookup (
        .cx     (cell_x_c),
        .cy     (cell_y_c),
        .ship_c (ship_c)
    );

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_board) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = start_ok_c ? SCAN : FINISH;
                SCAN:    if (last_cell_c) state_d = FINISH;
                FINISH:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        r_d        = r_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        num_d      = num_q;
        new_d      = new_q;
        big_d      = big_q;
        temp_hit_d = temp_hit_q;
        total_d    = total_q;
        mask_d     = mask_q;
        sum_c      = '0;
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == FINISH);
        if (clear_board) begin
            num_d      = '0;
            new_d      = '0;
            big_d      = '0;
            temp_hit_d = 1'b0;
            total_d    = '0;
            mask_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        num_d      = '0;
                        new_d      = '0;
                        big_d      = '0;
                        temp_hit_d = 1'b0;
                        if (start_ok_c) begin
                            x_d  = x;
                            y_d  = y;
                            r_d  = r_clamp_c;
                            dx_d = -$signed(OFF_W'(r_clamp_c));
                            dy_d = -$signed(OFF_W'(r_clamp_c));
                        end
                    end
                end
                SCAN: begin
                    // Off-board cells read back as WATER, so no separate range test.
                    if (ship_c != WATER) begin
                        num_d = num_q + CNT_W'(1);
                        if (ship_w_c > big_q) big_d = ship_w_c;
                        if (!mask_q[idx_c]) begin
                            new_d         = new_q + CNT_W'(1);
                            mask_d[idx_c] = 1'b1;
                        end
                    end
                    if (dx_q == r_s_c) begin
                        dx_d = -r_s_c;
                        dy_d = dy_q + off_t'(1);
                    end else begin
                        dx_d = dx_q + off_t'(1);
                    end
                end
                default: ;
            endcase
            if (state_d == FINISH) begin
                temp_hit_d = (num_d != '0);
                sum_c      = (TOTAL_W+1)'(total_q) + (TOTAL_W+1)'(new_d);
                total_d    = sum_c[TOTAL_W] ? '1 : sum_c[TOTAL_W-1:0];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            x_q        <= '0;
            y_q        <= '0;
            r_q        <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            temp_hit_q <= 1'b0;
            num_q      <= '0;
            new_q      <= '0;
            big_q      <= '0;
            total_q    <= '0;
            mask_q     <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            r_q        <= r_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            temp_hit_q <= temp_hit_d;
            num_q      <= num_d;
            new_q      <= new_d;
            big_q      <= big_d;
            total_q    <= total_d;
            mask_q     <= mask_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign temp_hit     = temp_hit_q;
    assign num_hits     = num_q;
    assign new_hits     = new_q;
    assign biggest_ship = big_q;
    assign total_hits   = total_q;

endmodule

// File: tb/tb_strike_resolver.sv
// Directed and random shots against a cell-by-cell board model of the strike resolver.
module tb_strike_resolver;

    localparam int GW = 10;
    localparam int GH = 10;
    localparam int MAXR = 2;
    localparam int TOT_MAX = 127;

    logic       clock = 1'b0;
    logic       reset_L = 1'b0;
    logic       start = 1'b0;
    logic [3:0] x = '0;
    logic [3:0] y = '0;
    logic [1:0] radius = '0;
    logic       wrong = 1'b0;
    logic       score_this = 1'b0;
    logic       clear_board = 1'b0;
    logic       busy, done, temp_hit;
    logic [4:0] num_hits, new_hits, biggest_ship;
    logic [6:0] total_hits;

    int errors = 0;
    int checks = 0;
    int board [GW][GH];
    bit struck [GW][GH];
    int total_m = 0;

    strike_resolver dut (
        .clock        (clock),
        .reset_L      (reset_L),
        .start        (start),
        .x            (x),
        .y            (y),
        .radius       (radius),
        .wrong        (wrong),
        .score_this   (score_this),
        .clear_board  (clear_board),
        .busy         (busy),
        .done         (done),
        .temp_hit     (temp_hit),
        .num_hits     (num_hits),
        .new_hits     (new_hits),
        .biggest_ship (biggest_ship),
        .total_hits   (total_hits)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic place(input int code, input int x0, input int y0, input int len, input bit vert);
        for (int k = 0; k < len; k++) begin
            if (vert) board[x0][y0+k] = code;
            else      board[x0+k][y0] = code;
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < GW; i++)
            for (int j = 0; j < GH; j++) struck[i][j] = 1'b0;
        total_m = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Fire one shot, wait for done with a bound, and compare everything to the model.
    task automatic do_shot(input int sx, input int sy, input int srad, input bit swrong,
                           input bit sscore, input string tag);
        int r, lat, e_lat, e_num, e_new, e_big;
        r = (srad > MAXR) ? MAXR : srad;
        e_num = 0; e_new = 0; e_big = 0;
        if (swrong || !sscore) begin
            e_lat = 1;
        end else begin
            e_lat = (2*r+1)*(2*r+1) + 1;
            for (int dy = -r; dy <= r; dy++) begin
                for (int dx = -r; dx <= r; dx++) begin
                    int cx, cy;
                    cx = sx + dx;
                    cy = sy + dy;
                    if (cx >= 0 && cx < GW && cy >= 0 && cy < GH && board[cx][cy] != 0) begin
                        e_num++;
                        if (board[cx][cy] > e_big) e_big = board[cx][cy];
                        if (!struck[cx][cy]) begin
                            e_new++;
                            struck[cx][cy] = 1'b1;
                        end
                    end
                end
            end
            total_m = (total_m + e_new > TOT_MAX) ? TOT_MAX : total_m + e_new;
        end
        x = 4'(sx); y = 4'(sy); radius = 2'(srad);
        wrong = swrong; score_this = sscore; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(e_lat));
        check({tag, ".temp_hit"}, 32'(temp_hit), 32'(e_num != 0));
        check({tag, ".num_hits"}, 32'(num_hits), 32'(e_num));
        check({tag, ".new_hits"}, 32'(new_hits), 32'(e_new));
        check({tag, ".biggest"}, 32'(biggest_ship), 32'(e_big));
        check({tag, ".total"}, 32'(total_hits), 32'(total_m));
        tick();
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check({tag, ".idle"}, 32'(busy), 32'd0);
        check({tag, ".hold"}, 32'(num_hits), 32'(e_num));
    endtask

    initial begin
        int seen;
        for (int i = 0; i < GW; i++)
            for (int j = 0; j < GH; j++) board[i][j] = 0;
        place(5, 1, 2, 5, 1'b0);
        place(4, 0, 5, 4, 1'b1);
        place(3, 4, 6, 3, 1'b0);
        place(2, 8, 8, 2, 1'b1);
        clear_model();

        // Reset state
        #12;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.num", 32'(num_hits), 32'd0);
        check("reset.total", 32'(total_hits), 32'd0);
        @(negedge clock);
        reset_L = 1'b1;
        tick();

        // Directed shots from the layout scenarios
        do_shot(3, 2, 0, 1'b0, 1'b1, "single");
        do_shot(3, 2, 0, 1'b0, 1'b1, "repeat");
        do_shot(4, 2, 1, 1'b0, 1'b1, "area3x3");
        do_shot(0, 0, 1, 1'b0, 1'b1, "corner");
        do_shot(8, 9, 3, 1'b0, 1'b1, "clamped");

        // Asynchronous reset in the middle of a scan
        x = 4'd4; y = 4'd2; radius = 2'd2; wrong = 1'b0; score_this = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2 reset_L = 1'b0;
        #1;
        check("async.busy", 32'(busy), 32'd0);
        check("async.num", 32'(num_hits), 32'd0);
        check("async.big", 32'(biggest_ship), 32'd0);
        check("async.total", 32'(total_hits), 32'd0);
        clear_model();
        @(negedge clock);
        reset_L = 1'b1;
        tick();
        do_shot(3, 2, 0, 1'b0, 1'b1, "post_reset");

        // Null shots
        do_shot(3, 2, 1, 1'b1, 1'b1, "wrong");
        do_shot(5, 2, 2, 1'b0, 1'b0, "unscored");

        // clear_board aborts a scan
        x = 4'd4; y = 4'd2; radius = 2'd1; wrong = 1'b0; score_this = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        clear_board = 1'b1;
        tick();
        clear_board = 1'b0;
        clear_model();
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.total", 32'(total_hits), 32'd0);
        check("abort.num", 32'(num_hits), 32'd0);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (done === 1'b1) seen++;
            tick();
        end
        check("abort.no_done", 32'(seen), 32'd0);

        // start coincident with clear_board is dropped
        start = 1'b1; clear_board = 1'b1;
        tick();
        start = 1'b0; clear_board = 1'b0;
        check("clr_start.busy", 32'(busy), 32'd0);
        tick();
        check("clr_start.busy2", 32'(busy), 32'd0);
        do_shot(3, 2, 0, 1'b0, 1'b1, "after_clear");

        // Random shots with occasional new games
        for (int n = 0; n < 40; n++) begin
            if (n % 13 == 12) begin
                clear_board = 1'b1;
                tick();
                clear_board = 1'b0;
                clear_model();
                check("rand.clear_total", 32'(total_hits), 32'd0);
            end
            do_shot(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 7) != 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
